// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: Horner accumulation, one digit per clock, MSD first.
// Optional digit range check enabled by defining BCD2BIN_RANGE_CHECK_EN.
module bcd2bin_seq #(
    parameter int NDIG = 3,
    parameter int BW   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic              busy,
    output logic              valid,
    output logic [BW-1:0]     bin_out,
    output logic              err
);

    // state | meaning
    // IDLE  | waiting for start; captures bcd_in when start is high
    // CONV  | one digit consumed per edge, from digit NDIG-1 down to digit 0
    typedef enum logic {IDLE, CONV} state_t;

    state_t            state, state_nxt;
    logic [4*NDIG-1:0] cap, cap_nxt;
    logic [BW-1:0]     acc, acc_nxt;
    logic [1:0]        idx, idx_nxt;
    logic              busy_nxt, valid_nxt;
    logic [BW-1:0]     bin_nxt;

    logic [15:0]       cap_ext;
    logic [3:0]        digit;
    logic [BW+3:0]     acc_wide;
    logic [BW+3:0]     horner;

    assign cap_ext  = 16'(cap);
    assign digit    = cap_ext[{idx, 2'b00} +: 4];
    assign acc_wide = {4'b0000, acc};
    // acc*10 without a multiplier; keeping only BW bits each step equals truncating at the end
    assign horner   = (acc_wide << 3) + (acc_wide << 1) + {{BW{1'b0}}, digit};

`ifdef BCD2BIN_RANGE_CHECK_EN
    logic bad, bad_nxt;
    logic err_q, err_nxt;

    function automatic logic has_bad_digit(input logic [4*NDIG-1:0] v);
        logic found;
        found = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (v[4*k +: 4] > 4'd9) found = 1'b1;
        end
        return found;
    endfunction

    always_comb begin
        bad_nxt = bad;
        err_nxt = err_q;
        if (state == IDLE && start) bad_nxt = has_bad_digit(bcd_in);
        if (state == CONV && idx == 2'd0) err_nxt = bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            bad   <= bad_nxt;
            err_q <= err_nxt;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cap_nxt   = cap;
        acc_nxt   = acc;
        idx_nxt   = idx;
        busy_nxt  = busy;
        valid_nxt = 1'b0;
        bin_nxt   = bin_out;
        case (state)
            IDLE: begin
                if (start) begin
                    cap_nxt   = bcd_in;
                    acc_nxt   = '0;
                    idx_nxt   = 2'(NDIG - 1);
                    busy_nxt  = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                acc_nxt = horner[BW-1:0];
                idx_nxt = idx - 2'd1;
                if (idx == 2'd0) begin
                    bin_nxt   = horner[BW-1:0];
`ifdef BCD2BIN_RANGE_CHECK_EN
                    if (bad) bin_nxt = '0;
`endif
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    idx_nxt   = 2'd0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cap     <= '0;
            acc     <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            bin_out <= '0;
        end else begin
            state   <= state_nxt;
            cap     <= cap_nxt;
            acc     <= acc_nxt;
            idx     <= idx_nxt;
            busy    <= busy_nxt;
            valid   <= valid_nxt;
            bin_out <= bin_nxt;
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq (NDIG=3, BW=10) against a decimal-arithmetic reference.
module tb_bcd2bin_seq;
    localparam int NDIG = 3;
    localparam int BW   = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [4*NDIG-1:0] bcd_in = '0;
    logic              busy, valid, err;
    logic [BW-1:0]     bin_out;

    int total = 0;
    int bad   = 0;

    bcd2bin_seq #(.NDIG(NDIG), .BW(BW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
        .busy(busy), .valid(valid), .bin_out(bin_out), .err(err)
    );

    always #5 clk = ~clk;

    // Reference: place-value sum of the digits, reduced mod 2^BW; any digit above 9 flags an error.
    function automatic int ref_value(input logic [4*NDIG-1:0] v);
        int sum, weight;
        sum = 0;
        weight = 1;
        for (int k = 0; k < NDIG; k++) begin
            sum = sum + int'(v[4*k +: 4]) * weight;
            weight = weight * 10;
        end
        return sum % (1 << BW);
    endfunction

    function automatic int ref_bad(input logic [4*NDIG-1:0] v);
        int b;
        b = 0;
        for (int k = 0; k < NDIG; k++) if (v[4*k +: 4] > 4'd9) b = 1;
        return b;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [4*NDIG-1:0] v);
        @(negedge clk);
        bcd_in = v;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Called at the negedge right after the capture edge; returns at the negedge of the valid cycle.
    task automatic finish(input logic [4*NDIG-1:0] v, input bit noise);
        int lat;
        int exp_bin, exp_err;
        exp_err = 0;
        exp_bin = ref_value(v);
`ifdef BCD2BIN_RANGE_CHECK_EN
        exp_err = ref_bad(v);
        if (exp_err != 0) exp_bin = 0;
`endif
        lat = 0;
        chk("busy_first", int'(busy), 1);
        chk("no_early_valid", int'(valid), 0);
        while (!valid && lat < 12) begin
            if (noise) begin
                bcd_in = 12'($urandom);
                start  = 1'($urandom);
            end
            @(negedge clk);
            lat++;
            if (!valid && lat < NDIG) chk("busy_mid", int'(busy), 1);
        end
        start = 1'b0;
        chk("latency", lat, NDIG);
        chk("busy_done", int'(busy), 0);
        chk("bin_out", int'(bin_out), exp_bin);
        chk("err", int'(err), exp_err);
    endtask

    task automatic conv(input logic [4*NDIG-1:0] v, input bit noise);
        launch(v);
        finish(v, noise);
        @(negedge clk);
        chk("valid_one_cycle", int'(valid), 0);
        chk("idle_after", int'(busy), 0);
    endtask

    initial begin
        logic [4*NDIG-1:0] r;
        int seen_valid;
        int exp_bin;

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_bin", int'(bin_out), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        conv(12'h999, 1'b0);
        chk("h999_direct", int'(bin_out), 999);
        conv(12'h000, 1'b0);
        conv(12'h405, 1'b0);

        // back-to-back: start held in the valid cycle with a new operand
        launch(12'h311);
        finish(12'h311, 1'b0);
        bcd_in = 12'h250;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        chk("b2b_valid_low", int'(valid), 0);
        finish(12'h250, 1'b0);
        @(negedge clk);
        chk("b2b_single_valid", int'(valid), 0);

        // operand changes and stray start pulses during CONV
        conv(12'h468, 1'b1);

        // reset one cycle into a conversion
        launch(12'h777);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_bin", int'(bin_out), 0);
        chk("abort_err", int'(err), 0);
        seen_valid = 0;
        repeat (4) begin
            @(negedge clk);
            if (valid) seen_valid = 1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (valid) seen_valid = 1;
        end
        chk("abort_no_valid", seen_valid, 0);
        conv(12'h123, 1'b0);

        // non-BCD digit
        conv(12'h1A3, 1'b0);
        exp_bin = 203;
`ifdef BCD2BIN_RANGE_CHECK_EN
        exp_bin = 0;
`endif
        chk("h1A3_direct", int'(bin_out), exp_bin);

        // randomized operands, mostly legal BCD, some raw nibbles
        for (int i = 0; i < 30; i++) begin
            if (i % 4 == 3) r = 12'($urandom);
            else r = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            conv(r, 1'(i % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
